// File: rtl/ecpri_tx_if.sv
// ecpri_tx_if: request, RAM-port and status bundle between ecpri_tx and its RAMs/controller.
//   master (ecpri_tx side): in  send_write_resp, send_read_resp, resp_payload_len, data_0, data_1
//                           out addr_0, oe_0, addr_1, oe_1, addr_2, data_2, we_2, tx_busy, tx_done, tx_len
//   slave: mirror of master.
interface ecpri_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  send_write_resp;
    logic                  send_read_resp;
    logic [7:0]            resp_payload_len;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [DATA_WIDTH-1:0] data_0;
    logic                  oe_0;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] data_1;
    logic                  oe_1;
    logic [ADDR_WIDTH-1:0] addr_2;
    logic [DATA_WIDTH-1:0] data_2;
    logic                  we_2;
    logic                  tx_busy;
    logic                  tx_done;
    logic [ADDR_WIDTH-1:0] tx_len;
    modport master (
        input  send_write_resp, send_read_resp, resp_payload_len, data_0, data_1,
        output addr_0, oe_0, addr_1, oe_1, addr_2, data_2, we_2, tx_busy, tx_done, tx_len
    );
    modport slave (
        output send_write_resp, send_read_resp, resp_payload_len, data_0, data_1,
        input  addr_0, oe_0, addr_1, oe_1, addr_2, data_2, we_2, tx_busy, tx_done, tx_len
    );
endinterface

// File: rtl/ecpri_tx.sv
// ecpri_tx: builds an eCPRI Remote Memory Access response frame byte by byte into the tx Ethernet RAM.
//   clk, reset (async, active-high) plain ports; bus (ecpri_tx_if.master) carries:
//   send_read_resp/send_write_resp/resp_payload_len request, header RAM read (addr_0/oe_0/data_0),
//   payload RAM read (addr_1/oe_1/data_1), tx RAM write (addr_2/data_2/we_2), tx_busy/tx_done/tx_len status.
//   Optional macro ECPRI_TX_PAD_EN: zero-pads frames shorter than 60 bytes up to 60.
module ecpri_tx #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] PAYLOAD_BASE = '0,
    parameter logic [ADDR_WIDTH-1:0] TX_BASE      = '0,
    parameter logic [15:0]           ETHERTYPE    = 16'hAEFE
) (
    input logic       clk,
    input logic       reset,
    ecpri_tx_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, ETH_HDR, ECPRI_HDR, RMA_HDR, PAYLOAD,
`ifdef ECPRI_TX_PAD_EN
        PAD,
`endif
        DONE
    } state_t;

    typedef enum logic [1:0] {SRC_C, SRC_H, SRC_P} src_t;

    function automatic logic [ADDR_WIDTH-1:0] a(input int v);
        return ADDR_WIDTH'(v);
    endfunction

    state_t                state, nxt, after_data;
    logic [ADDR_WIDTH-1:0] cnt, lraw, lraw_in, tx_len_in, tx_len_r, hdr_a, wr_idx;
    logic [7:0]            n;
    logic                  rd, req, fetching, wr_vld, tx_done_r;
    src_t                  src, wr_src;
    logic [DATA_WIDTH-1:0] cbyte, wr_const;
    logic [15:0]           p;

    assign req       = bus.send_read_resp | bus.send_write_resp;
    assign lraw_in   = bus.send_read_resp ? a(30) + ADDR_WIDTH'(bus.resp_payload_len) : a(30);
`ifdef ECPRI_TX_PAD_EN
    assign tx_len_in = lraw_in < a(60) ? a(60) : lraw_in;
`else
    assign tx_len_in = lraw_in;
`endif
    assign p = rd ? 16'd12 + {8'h00, n} : 16'd12;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
`ifdef ECPRI_TX_PAD_EN
        after_data = lraw < a(60) ? PAD : DONE;
`else
        after_data = DONE;
`endif
        nxt = state;
        case (state)
            IDLE:      nxt = req ? ETH_HDR : IDLE;
            ETH_HDR:   nxt = cnt == a(13) ? ECPRI_HDR : ETH_HDR;
            ECPRI_HDR: nxt = cnt == a(17) ? RMA_HDR : ECPRI_HDR;
            RMA_HDR:   nxt = cnt != a(29) ? RMA_HDR : (rd && n != 8'd0) ? PAYLOAD : after_data;
            PAYLOAD:   nxt = cnt == lraw - a(1) ? after_data : PAYLOAD;
`ifdef ECPRI_TX_PAD_EN
            PAD:       nxt = cnt == a(59) ? DONE : PAD;
`endif
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Fetch stage: cnt is the frame offset whose source byte is requested this cycle;
    // the matching write happens one cycle later from the registered write stage.
    always_comb begin
        src   = SRC_C;
        hdr_a = cnt;
        cbyte = '0;
        if (state == PAYLOAD)
            src = SRC_P;
        else if (cnt < a(6)) begin
            src   = SRC_H;
            hdr_a = cnt + a(6);
        end else if (cnt < a(12)) begin
            src   = SRC_H;
            hdr_a = cnt - a(6);
        end else if (cnt == a(12))
            cbyte = ETHERTYPE[15:8];
        else if (cnt == a(13))
            cbyte = ETHERTYPE[7:0];
        else if (cnt == a(14))
            cbyte = 8'h10;
        else if (cnt == a(15))
            cbyte = 8'h04;
        else if (cnt == a(16))
            cbyte = p[15:8];
        else if (cnt == a(17))
            cbyte = p[7:0];
        else if (cnt == a(19))
            cbyte = rd ? 8'h01 : 8'h11;
        else if (cnt == a(18) || (cnt >= a(20) && cnt <= a(27)) || (!rd && cnt <= a(29)))
            src = SRC_H;
        else if (cnt == a(29))
            cbyte = n;
    end

    always_comb begin
        fetching    = state != IDLE && state != DONE;
        bus.tx_busy = state != IDLE;
        bus.oe_0    = fetching && src == SRC_H;
        bus.oe_1    = fetching && src == SRC_P;
        bus.addr_0  = bus.oe_0 ? hdr_a : '0;
        bus.addr_1  = bus.oe_1 ? PAYLOAD_BASE + cnt - a(30) : '0;
        bus.we_2    = wr_vld;
        bus.addr_2  = wr_vld ? TX_BASE + wr_idx : '0;
        bus.data_2  = !wr_vld ? '0 : wr_src == SRC_H ? bus.data_0 : wr_src == SRC_P ? bus.data_1 : wr_const;
        bus.tx_done = tx_done_r;
        bus.tx_len  = tx_len_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rd        <= 1'b0;
            n         <= '0;
            lraw      <= '0;
            tx_len_r  <= '0;
            tx_done_r <= 1'b0;
            wr_vld    <= 1'b0;
            wr_idx    <= '0;
            wr_src    <= SRC_C;
            wr_const  <= '0;
        end else begin
            cnt       <= state == IDLE ? '0 : cnt + a(1);
            tx_done_r <= state == DONE;
            wr_vld    <= fetching;
            wr_idx    <= cnt;
            wr_src    <= src;
            wr_const  <= cbyte;
            if (state == IDLE && req) begin
                rd       <= bus.send_read_resp;
                n        <= bus.resp_payload_len;
                lraw     <= lraw_in;
                tx_len_r <= tx_len_in;
            end
        end
    end
endmodule

// File: tb/tb_ecpri_tx.sv
// tb_ecpri_tx: randomized self-checking bench for ecpri_tx against a frame-level reference model.
module tb_ecpri_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ecpri_tx_if bus();
    ecpri_tx dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] hdr [0:63];
    logic [7:0] pay [0:65535];
    logic [7:0] txm [0:65535];
    logic       rd0, rd1;
    logic [7:0] q0, q1;

    always @(negedge clk) begin
        rd0 <= bus.oe_0;
        q0  <= hdr[bus.addr_0[5:0]];
        rd1 <= bus.oe_1;
        q1  <= pay[bus.addr_1];
        if (bus.we_2) txm[bus.addr_2] <= bus.data_2;
    end

    always @(posedge clk) begin
        if (rd0) bus.data_0 <= q0;
        if (rd1) bus.data_1 <= q1;
    end

    int cyc = 0;
    int done_cnt, done_cyc, done_len, done_busy, we_cnt, first_we, bad_addr, oe1_cnt;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_len  = int'(bus.tx_len);
            done_busy = int'(bus.tx_busy);
        end
        if (bus.we_2) begin
            if (bus.addr_2 != 16'(we_cnt)) bad_addr++;
            if (we_cnt == 0) first_we = cyc;
            we_cnt++;
        end
        if (bus.oe_1) oe1_cnt++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] expq[$];

    function automatic void model(input bit rd, input int n);
        int p = rd ? 12 + n : 12;
        expq.delete();
        for (int i = 6; i < 12; i++) expq.push_back(hdr[i]);
        for (int i = 0; i < 6; i++) expq.push_back(hdr[i]);
        expq.push_back(8'hAE);
        expq.push_back(8'hFE);
        expq.push_back(8'h10);
        expq.push_back(8'h04);
        expq.push_back(8'(p >> 8));
        expq.push_back(8'(p));
        expq.push_back(hdr[18]);
        expq.push_back(rd ? 8'h01 : 8'h11);
        for (int i = 20; i < 28; i++) expq.push_back(hdr[i]);
        expq.push_back(rd ? 8'h00 : hdr[28]);
        expq.push_back(rd ? 8'(n) : hdr[29]);
        if (rd) for (int i = 0; i < n; i++) expq.push_back(pay[i]);
`ifdef ECPRI_TX_PAD_EN
        while (expq.size() < 60) expq.push_back(8'h00);
`endif
    endfunction

    function automatic void rand_hdr();
        for (int i = 0; i < 64; i++) hdr[i] = 8'($urandom);
    endfunction

    task automatic frame(input bit rd, input bit wr, input int n, input bit poke, input string nm);
        int req, bad, len;
        done_cnt = 0; we_cnt = 0; bad_addr = 0; oe1_cnt = 0; first_we = -1; done_cyc = -1;
        @(negedge clk);
        bus.send_read_resp   = rd;
        bus.send_write_resp  = wr;
        bus.resp_payload_len = 8'(n);
        req = cyc;
        @(negedge clk);
        bus.send_read_resp   = 1'b0;
        bus.send_write_resp  = 1'b0;
        bus.resp_payload_len = 8'($urandom);
        check({nm, "_busy"}, bus.tx_busy, 1);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(negedge clk);
            if (poke) bus.send_write_resp = (cyc == req + 5);
        end
        bus.send_write_resp = 1'b0;
        check({nm, "_timeout"}, done_cnt > 0, 1);
        repeat (6) @(negedge clk);
        model(rd, n);
        len = expq.size();
        bad = 0;
        for (int i = 0; i < len; i++) if (txm[i] !== expq[i]) bad++;
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_time"}, done_cyc - req, len + 2);
        check({nm, "_first_we"}, first_we - req, 2);
        check({nm, "_we_count"}, we_cnt, len);
        check({nm, "_addr_seq"}, bad_addr, 0);
        check({nm, "_tx_len"}, done_len, len);
        check({nm, "_busy_at_done"}, done_busy, 0);
        check({nm, "_oe1_count"}, oe1_cnt, rd ? n : 0);
        check({nm, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        bus.send_read_resp   = 1'b0;
        bus.send_write_resp  = 1'b0;
        bus.resp_payload_len = 8'd0;
        for (int i = 0; i < 65536; i++) pay[i] = 8'($urandom);
        rand_hdr();
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.we_2, bus.oe_0, bus.oe_1, bus.tx_busy, bus.tx_done,
                                bus.tx_len, bus.addr_0, bus.addr_1, bus.addr_2, bus.data_2}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            hdr[i]     = i == 5 ? 8'h01 : i == 0 ? 8'h02 : 8'h00;
            hdr[i + 6] = i == 5 ? 8'h02 : i == 0 ? 8'h02 : 8'h00;
        end
        hdr[18] = 8'h5A;
        for (int i = 0; i < 8; i++) pay[i] = 8'hA0 + 8'(i);
        frame(1, 0, 8, 0, "read8");
        check("read8_byte0", txm[0], 8'h02);
        check("read8_byte11", txm[11], 8'h01);

        hdr[28] = 8'h00;
        hdr[29] = 8'h10;
        frame(0, 1, 16, 0, "write");
        check("write_byte19", txm[19], 8'h11);

        rand_hdr();
        frame(1, 1, 4, 0, "both");
        frame(1, 0, 12, 1, "poke_busy");
        frame(1, 0, 0, 0, "read0");

        begin
            int req;
            @(negedge clk);
            bus.send_read_resp   = 1'b1;
            bus.resp_payload_len = 8'd20;
            req = cyc;
            @(negedge clk);
            bus.send_read_resp = 1'b0;
            while (cyc < req + 10) @(negedge clk);
            reset = 1'b1;
            #1;
            check("midreset_outputs", {bus.we_2, bus.oe_0, bus.oe_1, bus.tx_busy, bus.tx_done,
                                       bus.tx_len, bus.addr_0, bus.addr_1, bus.addr_2, bus.data_2}, 0);
            we_cnt = 0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            check("midreset_no_we", we_cnt, 0);
        end
        frame(1, 0, 20, 0, "after_reset");

        for (int k = 0; k < 8; k++) begin
            bit rd = 1'($urandom);
            rand_hdr();
            frame(rd, rd ? 1'($urandom) : 1'b1, k == 0 ? 0 : int'($urandom_range(0, 255)), 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
